// File: rtl/spi_flash_ctrl.sv
// Byte-wide SPI master for a serial flash: mode 0, MSB first, one byte per wr strobe.
// SCK half-period is DIV clk cycles; cs_n is a separately controlled registered select.
module spi_flash_ctrl #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       wr,
    input  logic [7:0] tx_data,
    input  logic       cs_wr,
    input  logic       cs_val,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bitcnt_d  = bitcnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        case (state_q)
            IDLE: begin
                // cs_n may only move between bytes, never while a byte is on the wire
                if (cs_wr) cs_n_d = ~cs_val;
                if (wr) begin
                    tx_sh_d  = tx_data;
                    mosi_d   = tx_data[7];
                    bitcnt_d = 3'd7;
                    busy_d   = 1'b1;
                    div_d    = 8'd0;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 8'd0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], miso};
                    state_d = HIGH;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    sck_d = 1'b0;
                    if (bitcnt_q == 3'd0) begin
                        rx_data_d = rx_sh_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                        mosi_d   = tx_sh_q[6];
                        state_d  = LOW;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bitcnt_q  <= 3'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bitcnt_q  <= bitcnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: DIV=2 instance (index 0) and DIV=1 instance (index 1), observed
// by a wire-level monitor and compared against byte-level expectations.
module tb_spi_flash_ctrl;

    logic       clk = 1'b0;
    logic       resetq;
    logic       wr_a[2], cs_wr_a[2], cs_val_a[2], miso_a[2];
    logic [7:0] tx_a[2], rx_a[2];
    logic       busy_a[2], done_a[2], sck_a[2], mosi_a[2], cs_n_a[2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_flash_ctrl #(.DIV(2)) u_dut0 (
        .clk(clk), .resetq(resetq), .wr(wr_a[0]), .tx_data(tx_a[0]), .cs_wr(cs_wr_a[0]),
        .cs_val(cs_val_a[0]), .rx_data(rx_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .sck(sck_a[0]), .mosi(mosi_a[0]), .miso(miso_a[0]), .cs_n(cs_n_a[0]));

    spi_flash_ctrl #(.DIV(1)) u_dut1 (
        .clk(clk), .resetq(resetq), .wr(wr_a[1]), .tx_data(tx_a[1]), .cs_wr(cs_wr_a[1]),
        .cs_val(cs_val_a[1]), .rx_data(rx_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .sck(sck_a[1]), .mosi(mosi_a[1]), .miso(miso_a[1]), .cs_n(cs_n_a[1]));

    // Monitor: wire-level statistics; the flash model shifts mstream out MSB first, one bit per SCK fall.
    int          cyc_cnt = 0;
    int          busy_cyc[2], done_cyc[2], rises[2], falls[2], werr[2], runl[2];
    int          first_busy[2], last_busy[2], done_at[2];
    logic        psck[2], pbusy[2];
    logic [31:0] mbits[2];
    logic [23:0] mstream[2];

    always @(negedge clk) begin
        cyc_cnt++;
        for (int k = 0; k < 2; k++) begin
            int divk;
            divk = (k == 0) ? 2 : 1;
            if (busy_a[k]) begin
                busy_cyc[k]++;
                if (first_busy[k] < 0) first_busy[k] = cyc_cnt;
                last_busy[k] = cyc_cnt;
                if (pbusy[k] && sck_a[k] == psck[k]) runl[k]++;
                else begin
                    if (pbusy[k] && runl[k] != divk) werr[k]++;
                    runl[k] = 1;
                end
            end else if (pbusy[k]) begin
                if (runl[k] != divk) werr[k]++;
                runl[k] = 0;
            end
            if (done_a[k]) begin done_cyc[k]++; done_at[k] = cyc_cnt; end
            if (sck_a[k] && !psck[k]) begin rises[k]++; mbits[k] = {mbits[k][30:0], mosi_a[k]}; end
            if (!sck_a[k] && psck[k]) falls[k]++;
            psck[k]  = sck_a[k];
            pbusy[k] = busy_a[k];
            miso_a[k] = (falls[k] < 24) ? mstream[k][23 - falls[k]] : 1'b0;
        end
    end

    task automatic clr_mon(input int k, input logic [23:0] ms);
        busy_cyc[k] = 0; done_cyc[k] = 0; rises[k] = 0; falls[k] = 0; werr[k] = 0; runl[k] = 0;
        first_busy[k] = -1; last_busy[k] = -1; done_at[k] = -1;
        psck[k] = 1'b0; pbusy[k] = 1'b0; mbits[k] = 32'h0;
        mstream[k] = ms; miso_a[k] = ms[23];
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic start(input int k, input logic [7:0] d);
        wr_a[k] = 1'b1; tx_a[k] = d;
        cyc(1);
        wr_a[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while (busy_a[k] && t < 600) begin cyc(1); t++; end
        if (busy_a[k]) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle%0d: busy still %b after %0d cycles, required 0", k, busy_a[k], t);
        end
    endtask

    task automatic test_reset;
        resetq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_a[k] = 0; cs_wr_a[k] = 0; cs_val_a[k] = 0; tx_a[k] = 8'h00; clr_mon(k, 24'h0);
        end
        cyc(3);
        resetq = 1'b1;
        cyc(10);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (sck_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_sck%0d: got %b want 0", k, sck_a[k]); end
            n_chk++; if (cs_n_a[k] !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n%0d: got %b want 1", k, cs_n_a[k]); end
            n_chk++; if (mosi_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_mosi%0d: got %b want 0", k, mosi_a[k]); end
            n_chk++; if (busy_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy%0d: got %b want 0", k, busy_a[k]); end
            n_chk++; if (done_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done%0d: got %b want 0", k, done_a[k]); end
            n_chk++; if (rx_a[k] !== 8'h00) begin n_fail++; $display("FAIL reset_rx%0d: got %h want 00", k, rx_a[k]); end
        end
    endtask

    task automatic test_basic;
        int c;
        clr_mon(0, {8'h3C, 16'h0});
        c = cyc_cnt;
        cs_wr_a[0] = 1'b1; cs_val_a[0] = 1'b1;
        start(0, 8'hA5);
        cs_wr_a[0] = 1'b0;
        wait_idle(0);
        cyc(2);
        n_chk++; if (cs_n_a[0] !== 1'b0) begin n_fail++; $display("FAIL basic_cs_n: got %b want 0", cs_n_a[0]); end
        n_chk++; if (mbits[0][7:0] !== 8'hA5) begin n_fail++; $display("FAIL basic_mosi: got %h want a5", mbits[0][7:0]); end
        n_chk++; if (rises[0] != 8) begin n_fail++; $display("FAIL basic_rises: got %0d want 8", rises[0]); end
        n_chk++; if (werr[0] != 0) begin n_fail++; $display("FAIL basic_width: got %0d bad phases want 0", werr[0]); end
        n_chk++; if (busy_cyc[0] != 32) begin n_fail++; $display("FAIL basic_busy: got %0d want 32", busy_cyc[0]); end
        n_chk++; if (first_busy[0] != c + 1) begin n_fail++; $display("FAIL basic_busy_start: got %0d want %0d", first_busy[0], c + 1); end
        n_chk++; if (done_cyc[0] != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cyc[0]); end
        n_chk++; if (done_at[0] != c + 33) begin n_fail++; $display("FAIL basic_done_at: got %0d want %0d", done_at[0], c + 33); end
        n_chk++; if (rx_a[0] !== 8'h3C) begin n_fail++; $display("FAIL basic_rx: got %h want 3c", rx_a[0]); end
        n_chk++; if (sck_a[0] !== 1'b0 || mosi_a[0] !== 1'b1) begin n_fail++; $display("FAIL basic_idle_pins: got sck=%b mosi=%b want sck=0 mosi=1", sck_a[0], mosi_a[0]); end
    endtask

    task automatic test_ignore_wr;
        logic [7:0] m;
        m = 8'($urandom);
        clr_mon(0, {m, 16'h0});
        start(0, 8'h12);
        cyc(4);
        start(0, 8'hFF);
        wait_idle(0);
        cyc(40);
        n_chk++; if (rises[0] != 8) begin n_fail++; $display("FAIL ignwr_rises: got %0d want 8", rises[0]); end
        n_chk++; if (mbits[0][7:0] !== 8'h12) begin n_fail++; $display("FAIL ignwr_mosi: got %h want 12", mbits[0][7:0]); end
        n_chk++; if (busy_cyc[0] != 32) begin n_fail++; $display("FAIL ignwr_busy: got %0d want 32", busy_cyc[0]); end
        n_chk++; if (done_cyc[0] != 1) begin n_fail++; $display("FAIL ignwr_done: got %0d want 1", done_cyc[0]); end
        n_chk++; if (rx_a[0] !== m) begin n_fail++; $display("FAIL ignwr_rx: got %h want %h", rx_a[0], m); end
    endtask

    task automatic test_cs_hold;
        clr_mon(0, 24'h0);
        start(0, 8'h66);
        cyc(5);
        cs_wr_a[0] = 1'b1; cs_val_a[0] = 1'b0;
        cyc(1);
        cs_wr_a[0] = 1'b0;
        cyc(3);
        n_chk++; if (cs_n_a[0] !== 1'b0) begin n_fail++; $display("FAIL cs_mid: got %b want 0", cs_n_a[0]); end
        wait_idle(0);
        n_chk++; if (cs_n_a[0] !== 1'b0) begin n_fail++; $display("FAIL cs_end: got %b want 0", cs_n_a[0]); end
        cs_wr_a[0] = 1'b1; cs_val_a[0] = 1'b0;
        cyc(1);
        cs_wr_a[0] = 1'b0;
        n_chk++; if (cs_n_a[0] !== 1'b1) begin n_fail++; $display("FAIL cs_after: got %b want 1", cs_n_a[0]); end
    endtask

    task automatic test_reset_mid;
        int t = 0;
        logic [7:0] m;
        cs_wr_a[0] = 1'b1; cs_val_a[0] = 1'b1;
        clr_mon(0, 24'hFFFFFF);
        start(0, 8'hC3);
        cs_wr_a[0] = 1'b0;
        while (rises[0] < 3 && t < 200) begin cyc(1); t++; end
        n_chk++; if (rises[0] != 3) begin n_fail++; $display("FAIL rmid_reach: got %0d rises want 3", rises[0]); end
        resetq = 1'b0;
        #1;
        n_chk++; if (sck_a[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_sck: got %b want 0", sck_a[0]); end
        n_chk++; if (cs_n_a[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_cs_n: got %b want 1", cs_n_a[0]); end
        n_chk++; if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy_a[0]); end
        n_chk++; if (rx_a[0] !== 8'h00) begin n_fail++; $display("FAIL rmid_rx: got %h want 00", rx_a[0]); end
        cyc(2);
        resetq = 1'b1;
        cyc(5);
        n_chk++; if (done_cyc[0] != 0) begin n_fail++; $display("FAIL rmid_nodone: got %0d want 0", done_cyc[0]); end
        m = 8'($urandom);
        clr_mon(0, {m, 16'h0});
        start(0, 8'h5A);
        wait_idle(0);
        cyc(1);
        n_chk++; if (mbits[0][7:0] !== 8'h5A) begin n_fail++; $display("FAIL rmid_mosi: got %h want 5a", mbits[0][7:0]); end
        n_chk++; if (rises[0] != 8 || werr[0] != 0) begin n_fail++; $display("FAIL rmid_clk: got %0d rises %0d bad phases want 8 0", rises[0], werr[0]); end
        n_chk++; if (done_cyc[0] != 1) begin n_fail++; $display("FAIL rmid_done: got %0d want 1", done_cyc[0]); end
        n_chk++; if (rx_a[0] !== m) begin n_fail++; $display("FAIL rmid_rx2: got %h want %h", rx_a[0], m); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d, m;
            logic       v;
            d = 8'($urandom); m = 8'($urandom); v = 1'($urandom);
            clr_mon(0, {m, 16'h0});
            cs_wr_a[0] = 1'b1; cs_val_a[0] = v;
            start(0, d);
            cs_wr_a[0] = 1'b0;
            wait_idle(0);
            cyc(1);
            n_chk++; if (cs_n_a[0] !== ~v) begin n_fail++; $display("FAIL rnd%0d_cs_n: got %b want %b", i, cs_n_a[0], ~v); end
            n_chk++; if (mbits[0][7:0] !== d) begin n_fail++; $display("FAIL rnd%0d_mosi: got %h want %h", i, mbits[0][7:0], d); end
            n_chk++; if (rx_a[0] !== m) begin n_fail++; $display("FAIL rnd%0d_rx: got %h want %h", i, rx_a[0], m); end
            n_chk++; if (rises[0] != 8 || busy_cyc[0] != 32) begin n_fail++; $display("FAIL rnd%0d_timing: got %0d rises %0d busy want 8 32", i, rises[0], busy_cyc[0]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  txs[3];
        logic [23:0] ms;
        int t;
        txs[0] = 8'h9F; txs[1] = 8'h00; txs[2] = 8'h00;
        ms = 24'($urandom);
        clr_mon(1, ms);
        start(1, txs[0]);
        for (int b = 1; b < 3; b++) begin
            t = 0;
            while (!done_a[1] && t < 100) begin cyc(1); t++; end
            n_chk++; if (rx_a[1] !== ms[23 - 8*(b-1) -: 8]) begin n_fail++; $display("FAIL b2b_rx%0d: got %h want %h", b - 1, rx_a[1], ms[23 - 8*(b-1) -: 8]); end
            start(1, txs[b]);
        end
        wait_idle(1);
        cyc(2);
        n_chk++; if (rises[1] != 24) begin n_fail++; $display("FAIL b2b_rises: got %0d want 24", rises[1]); end
        n_chk++; if (mbits[1][23:0] !== {txs[0], txs[1], txs[2]}) begin n_fail++; $display("FAIL b2b_mosi: got %h want 9f0000", mbits[1][23:0]); end
        n_chk++; if (busy_cyc[1] != 48) begin n_fail++; $display("FAIL b2b_busy: got %0d want 48", busy_cyc[1]); end
        n_chk++; if (last_busy[1] - first_busy[1] + 1 != 50) begin n_fail++; $display("FAIL b2b_span: got %0d want 50", last_busy[1] - first_busy[1] + 1); end
        n_chk++; if (done_cyc[1] != 3 || werr[1] != 0) begin n_fail++; $display("FAIL b2b_done: got %0d dones %0d bad phases want 3 0", done_cyc[1], werr[1]); end
        n_chk++; if (rx_a[1] !== ms[7:0]) begin n_fail++; $display("FAIL b2b_rx2: got %h want %h", rx_a[1], ms[7:0]); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ignore_wr;
        test_cs_hold;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
